sequencia_tx: RTL and testbench

//  Transmit side of the 7-bit character + strobe interface consumed by Circuito (state-code recognizer).

---
 rtl/sequencia_tx_if.sv | 24 ++
 rtl/sequencia_tx.sv | 125 ++++++++++++
 tb/tb_sequencia_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sequencia_tx_if.sv
// Command and symbol bus between a message requester and the sequencia_tx replay engine.
// Latency: none, wires only.
// Backpressure: none; start is honoured only while busy is low.
interface sequencia_tx_if;
    logic       start;
    logic [2:0] msg_sel;
    logic       abort;
    logic [6:0] sym;
    logic       sym_valid;
    logic       rec_clr;
    logic       busy;
    logic       done;
    logic [3:0] expect_code;

    modport master (
        output start, msg_sel, abort,
        input  sym, sym_valid, rec_clr, busy, done, expect_code
    );

    modport slave (
        input  start, msg_sel, abort,
        output sym, sym_valid, rec_clr, busy, done, expect_code
    );
endinterface

// File: rtl/sequencia_tx.sv
// Replays one of 8 ROM test messages as 7-bit symbols with a strobe, plus recognizer clear and expected code.
// Latency: start edge -> rec_clr next cycle (CLR_EN) -> first strobe, then one strobe every GAP+1 cycles.
// Backpressure: none; start while busy is dropped, abort returns to idle without a done pulse.
module sequencia_tx #(
    parameter int unsigned GAP    = 1,
    parameter bit          CLR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    sequencia_tx_if.slave bus
);
    localparam logic [6:0] T_X   = 7'b1011000;
    localparam logic [6:0] T_K   = 7'b1101011;
    localparam logic [6:0] T_O   = 7'b1001111;
    localparam logic [6:0] T_PAR = 7'b0101000;
    localparam logic [6:0] T_FF  = 7'b0001100;
    localparam logic [6:0] T_TWO = 7'b0110010;
    localparam logic [6:0] T_SYN = 7'b0010110;
    localparam logic [6:0] T_HSH = 7'b0100011;
    localparam logic [6:0] T_NUL = 7'b0000000;

    // Token 0 sits in the least-significant slot of each packed entry.
    localparam logic [4:0][6:0] ROM [8] = '{
        {T_NUL, T_NUL, T_TWO, T_K,   T_X  },
        {T_NUL, T_NUL, T_HSH, T_FF,  T_PAR},
        {T_NUL, T_HSH, T_FF,  T_PAR, T_O  },
        {T_NUL, T_NUL, T_NUL, T_O,   T_X  },
        {T_NUL, T_HSH, T_PAR, T_O,   T_K  },
        {T_TWO, T_K,   T_X,   T_K,   T_X  },
        {T_NUL, T_NUL, T_SYN, T_K,   T_SYN},
        {T_NUL, T_NUL, T_X,   T_TWO, T_K  }
    };
    localparam logic [2:0] MSG_LEN [8] = '{3'd3, 3'd3, 3'd4, 3'd2, 3'd4, 3'd5, 3'd3, 3'd3};
    localparam logic [3:0] MSG_CODE [8] = '{4'b1001, 4'b1010, 4'b1010, 4'b1000,
                                            4'b1010, 4'b1001, 4'b1000, 4'b1001};
    localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SEND, S_GAP, S_DONE} state_t;

    state_t     state;
    logic [2:0] msg;
    logic [2:0] idx;
    logic [3:0] gap_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            msg             <= 3'd0;
            idx             <= 3'd0;
            gap_cnt         <= 4'd0;
            bus.sym         <= 7'd0;
            bus.sym_valid   <= 1'b0;
            bus.rec_clr     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.expect_code <= 4'd0;
        end else begin
            // Strobe, clear and done are single-cycle pulses unless a state re-asserts them.
            bus.sym_valid <= 1'b0;
            bus.rec_clr   <= 1'b0;
            bus.done      <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            msg             <= bus.msg_sel;
                            idx             <= 3'd0;
                            bus.expect_code <= MSG_CODE[bus.msg_sel];
                            bus.busy        <= 1'b1;
                            if (CLR_EN) begin
                                state       <= S_CLR;
                                bus.rec_clr <= 1'b1;
                            end else begin
                                state         <= S_SEND;
                                bus.sym       <= ROM[bus.msg_sel][0];
                                bus.sym_valid <= 1'b1;
                            end
                        end
                    end
                    S_CLR: begin
                        state         <= S_SEND;
                        bus.sym       <= ROM[msg][idx];
                        bus.sym_valid <= 1'b1;
                    end
                    S_SEND: begin
                        if (idx == MSG_LEN[msg] - 3'd1) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            if (GAP == 0) begin
                                state         <= S_SEND;
                                bus.sym       <= ROM[msg][idx + 3'd1];
                                bus.sym_valid <= 1'b1;
                            end else begin
                                state   <= S_GAP;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state         <= S_SEND;
                            bus.sym       <= ROM[msg][idx];
                            bus.sym_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sequencia_tx.sv
// Bench for sequencia_tx: three parameterisations driven in lockstep, checked against a schedule model,
// plus a directed vector table and hand-written abort / async-reset sequences.
module tb_sequencia_tx;
    typedef struct packed {
        logic [6:0] sym;
        logic       sv;
        logic       rc;
        logic       dn;
        logic       bz;
        logic [3:0] ec;
    } obs_t;

    typedef struct {
        logic       s;
        logic [2:0] m;
        logic       a;
        obs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] msg_sel = 3'd0;
    logic       abort = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequencia_tx_if b0 ();
    sequencia_tx_if b1 ();
    sequencia_tx_if b2 ();

    assign b0.start = start; assign b0.msg_sel = msg_sel; assign b0.abort = abort;
    assign b1.start = start; assign b1.msg_sel = msg_sel; assign b1.abort = abort;
    assign b2.start = start; assign b2.msg_sel = msg_sel; assign b2.abort = abort;

    sequencia_tx #(.GAP(0), .CLR_EN(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    sequencia_tx #(.GAP(1), .CLR_EN(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    sequencia_tx #(.GAP(3), .CLR_EN(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

    obs_t act [3];
    assign act[0] = {b0.sym, b0.sym_valid, b0.rec_clr, b0.done, b0.busy, b0.expect_code};
    assign act[1] = {b1.sym, b1.sym_valid, b1.rec_clr, b1.done, b1.busy, b1.expect_code};
    assign act[2] = {b2.sym, b2.sym_valid, b2.rec_clr, b2.done, b2.busy, b2.expect_code};

    // Reference: each accepted message expands into the full per-cycle output waveform.
    int         gaps [3] = '{0, 1, 3};
    bit         clrs [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0] tok_val [8] = '{7'h58, 7'h6B, 7'h4F, 7'h28, 7'h0C, 7'h32, 7'h16, 7'h23};
    int         msg_tok [8][5] = '{'{0,1,5,0,0}, '{3,4,7,0,0}, '{2,3,4,7,0}, '{0,2,0,0,0},
                                   '{1,2,3,7,0}, '{0,1,0,1,5}, '{6,1,6,0,0}, '{1,5,0,0,0}};
    int         msg_len [8] = '{3, 3, 4, 2, 4, 5, 3, 3};
    logic [3:0] msg_code [8] = '{4'b1001, 4'b1010, 4'b1010, 4'b1000,
                                 4'b1010, 4'b1001, 4'b1000, 4'b1001};

    obs_t cur [3];
    obs_t sched [3][$];

    function automatic obs_t mk(logic [6:0] sym, logic sv, logic rc, logic dn, logic bz, logic [3:0] ec);
        obs_t o;
        o.sym = sym; o.sv = sv; o.rc = rc; o.dn = dn; o.bz = bz; o.ec = ec;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cur[k] = '0;
            sched[k].delete();
        end
    endtask

    task automatic model_go_idle(input int k);
        cur[k].sv = 1'b0; cur[k].rc = 1'b0; cur[k].dn = 1'b0; cur[k].bz = 1'b0;
        sched[k].delete();
    endtask

    task automatic model_start(input int k, input logic [2:0] m);
        obs_t o;
        o = mk(cur[k].sym, 1'b0, 1'b0, 1'b0, 1'b1, msg_code[m]);
        if (clrs[k]) begin
            o.rc = 1'b1; sched[k].push_back(o); o.rc = 1'b0;
        end
        for (int i = 0; i < msg_len[m]; i++) begin
            o.sym = tok_val[msg_tok[m][i]];
            o.sv = 1'b1; sched[k].push_back(o); o.sv = 1'b0;
            if (i < msg_len[m] - 1)
                for (int g = 0; g < gaps[k]; g++) sched[k].push_back(o);
        end
        o.dn = 1'b1; sched[k].push_back(o);
    endtask

    task automatic model_edge(input logic s, input logic [2:0] m, input logic a);
        for (int k = 0; k < 3; k++) begin
            if (cur[k].bz) begin
                if (a || sched[k].size() == 0) model_go_idle(k);
                else cur[k] = sched[k].pop_front();
            end else if (s) begin
                model_start(k, m);
                cur[k] = sched[k].pop_front();
            end else begin
                model_go_idle(k);
            end
        end
    endtask

    task automatic step(input logic s, input logic [2:0] m, input logic a);
        start = s; msg_sel = m; abort = a;
        @(posedge clk);
        model_edge(s, m, a);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("model_u%0d", k), 32'(act[k]), 32'(cur[k]));
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((act[0].bz || act[1].bz || act[2].bz) && n < 100) begin
            step(1'b0, 3'd0, 1'b0);
            n++;
        end
        if (n >= 100) chk("settle_timeout", 32'(n), 32'd0);
    endtask

    localparam logic [6:0] X = 7'h58, K = 7'h6B, TWO = 7'h32;
    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 3'd0, 1'b0, mk(7'h00, 0, 1, 0, 1, 4'b1001)};
        tbl[1] = '{1'b0, 3'd0, 1'b0, mk(X,     1, 0, 0, 1, 4'b1001)};
        tbl[2] = '{1'b0, 3'd0, 1'b0, mk(X,     0, 0, 0, 1, 4'b1001)};
        tbl[3] = '{1'b0, 3'd0, 1'b0, mk(K,     1, 0, 0, 1, 4'b1001)};
        tbl[4] = '{1'b1, 3'd3, 1'b0, mk(K,     0, 0, 0, 1, 4'b1001)};
        tbl[5] = '{1'b0, 3'd0, 1'b0, mk(TWO,   1, 0, 0, 1, 4'b1001)};
        tbl[6] = '{1'b0, 3'd0, 1'b0, mk(TWO,   0, 0, 1, 1, 4'b1001)};
        tbl[7] = '{1'b1, 3'd1, 1'b0, mk(TWO,   0, 0, 0, 0, 4'b1001)};
        tbl[8] = '{1'b0, 3'd0, 1'b0, mk(TWO,   0, 0, 0, 0, 4'b1001)};

        model_reset();
        #12;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_u%0d", k), 32'(act[k]), 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);

        // Message 0 on u1, with a start mid-message and another in the DONE cycle.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, tbl[i].m, tbl[i].a);
            chk($sformatf("vec%0d", i), 32'(act[1]), 32'(tbl[i].exp));
        end
        settle();

        // Abort during message 2, on the edge where u1 strobes its second token.
        step(1'b1, 3'd2, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b1);
        chk("abort_busy", 32'(act[1].bz), 32'd0);
        chk("abort_strobe", 32'(act[1].sv), 32'd0);
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step(1'b0, 3'd0, 1'b0);
                saw_done |= act[0].dn | act[1].dn | act[2].dn;
            end
            chk("abort_no_done", 32'(saw_done), 32'd0);
        end

        // Asynchronous reset while u1 sits in its inter-symbol gap.
        step(1'b1, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        chk("pre_reset_gap_busy", 32'(act[1].bz), 32'd1);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_reset_u%0d", k), 32'(act[k]), 32'd0);
        model_reset();
        #1 reset = 1'b1;

        // Every message in turn; expect_code must be valid on each done pulse.
        for (int m = 0; m < 8; m++) begin
            logic seen;
            int n;
            seen = 1'b0;
            n = 0;
            step(1'b1, 3'(m), 1'b0);
            while ((act[0].bz || act[1].bz || act[2].bz) && n < 100) begin
                step(1'b0, 3'd0, 1'b0);
                n++;
                if (act[1].dn) begin
                    seen = 1'b1;
                    chk($sformatf("done_code_m%0d", m), 32'(act[1].ec), 32'(msg_code[m]));
                end
            end
            chk($sformatf("done_seen_m%0d", m), 32'(seen), 32'd1);
        end

        // Random traffic with occasional aborts.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 3) == 0, 3'($urandom % 8), ($urandom % 25) == 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
